mac_acc_pipe: RTL and testbench

- Parametrised, pipelined multiply-accumulate engine. Successor to the single-channel free-running 12x12 MAC.
- Accumulates a stream of operand pairs into a dot product. The last pair of a vector is marked by in_last.
- Adds signed/unsigned mode, a configurable accumulator width, saturation with a sticky overflow flag, and a term count.
- Uses valid/ready handshakes on both the input and output sides. Sits between the operand sequencer and the result FIFO in the datapath.

---
 rtl/mac_acc_pipe_pkg.sv | 40 ++++
 rtl/mac_acc_pipe_sat_add.sv | 39 +++
 rtl/mac_acc_pipe.sv | 118 +++++++++++
 tb/tb_mac_acc_pipe.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_acc_pipe_pkg.sv
// Shared definitions for the pipelined multiply-accumulate engine:
// arithmetic mode constants, accumulator width check and saturation rails.
package mac_acc_pipe_pkg;

  localparam int MODE_UNSIGNED = 0;
  localparam int MODE_SIGNED   = 1;
  localparam int SAT_WRAP      = 0;
  localparam int SAT_CLAMP     = 1;

  // Widest accumulator the rail helpers can describe.
  localparam int MAX_ACC_W = 64;

  // The accumulator must hold a full product plus one guard bit.
  function automatic bit acc_w_ok(input int data_w, input int acc_w);
    return (acc_w >= 2 * data_w + 1) && (acc_w <= MAX_ACC_W);
  endfunction

  // Upper rail: 2^(w-1)-1 for signed, 2^w-1 for unsigned (low acc_w bits used).
  function automatic logic [MAX_ACC_W-1:0] sat_max(input int acc_w, input int signed_mode);
    logic [MAX_ACC_W-1:0] v;
    int                   top;
    v   = '0;
    top = (signed_mode != 0) ? acc_w - 1 : acc_w;
    for (int i = 0; i < MAX_ACC_W; i++) begin
      if (i < top) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Lower rail: -2^(w-1) for signed, 0 for unsigned (low acc_w bits used).
  function automatic logic [MAX_ACC_W-1:0] sat_min(input int acc_w, input int signed_mode);
    logic [MAX_ACC_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_ACC_W; i++) begin
      if ((signed_mode != 0) && (i == acc_w - 1)) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/mac_acc_pipe_sat_add.sv
// Combinational accumulator adder: one guard bit wider than the accumulator,
// flags results outside the accumulator range and optionally clamps to a rail.
module mac_sat_add
  import mac_acc_pipe_pkg::*;
#(
  parameter int ACC_W  = 32,
  parameter int SIGNED = MODE_UNSIGNED,
  parameter int SAT    = SAT_CLAMP
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  localparam logic [MAX_ACC_W-1:0] MAX_FULL = sat_max(ACC_W, SIGNED);
  localparam logic [MAX_ACC_W-1:0] MIN_FULL = sat_min(ACC_W, SIGNED);
  localparam logic [ACC_W-1:0]     MAX_V    = MAX_FULL[ACC_W-1:0];
  localparam logic [ACC_W-1:0]     MIN_V    = MIN_FULL[ACC_W-1:0];

  logic [ACC_W:0] s;

  // Extended add, range check, then clamp toward the side the true sum lies on.
  always_comb begin
    if (SIGNED != 0) begin
      s   = {a[ACC_W-1], a} + {b[ACC_W-1], b};
      ovf = s[ACC_W] ^ s[ACC_W-1];
    end else begin
      s   = {1'b0, a} + {1'b0, b};
      ovf = s[ACC_W];
    end
    sum = s[ACC_W-1:0];
    if ((SAT != 0) && ovf) begin
      // In signed mode the guard bit carries the true sign of the sum.
      sum = ((SIGNED != 0) && s[ACC_W]) ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/mac_acc_pipe.sv
// Two-stage multiply-accumulate engine with valid/ready on both sides.
// Stage 1 registers the product; stage 2 folds it into the running sum and,
// on the last term of a vector, publishes the result with overflow and count.
module mac_acc_pipe
  import mac_acc_pipe_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int ACC_W  = 32,
  parameter int SIGNED = MODE_UNSIGNED,
  parameter int SAT    = SAT_CLAMP,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_1,
  input  logic [DATA_W-1:0] in_2,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out,
  output logic              out_ovf,
  output logic [CNT_W-1:0]  out_cnt
);

  localparam int PROD_W = 2 * DATA_W;

  if (!acc_w_ok(DATA_W, ACC_W)) begin : g_bad_acc_w
    $error("mac_acc_pipe: ACC_W must be at least 2*DATA_W+1");
  end

  logic              adv;
  logic              accept;
  logic [PROD_W-1:0] a_ext;
  logic [PROD_W-1:0] b_ext;
  logic [PROD_W-1:0] prod;
  logic              v1;
  logic              last1;
  logic [PROD_W-1:0] p1;
  logic [ACC_W-1:0]  p1_ext;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  sum;
  logic              sum_ovf;
  logic              ovf_acc;
  logic [CNT_W-1:0]  cnt;

  // The whole pipe freezes only while a finished result waits for downstream.
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  // Operand extension and product; the low PROD_W bits of a product of
  // extended operands are exact for both signed and unsigned inputs.
  always_comb begin
    if (SIGNED != 0) begin
      a_ext  = {{DATA_W{in_1[DATA_W-1]}}, in_1};
      b_ext  = {{DATA_W{in_2[DATA_W-1]}}, in_2};
      p1_ext = {{(ACC_W-PROD_W){p1[PROD_W-1]}}, p1};
    end else begin
      a_ext  = {{DATA_W{1'b0}}, in_1};
      b_ext  = {{DATA_W{1'b0}}, in_2};
      p1_ext = {{(ACC_W-PROD_W){1'b0}}, p1};
    end
    prod = a_ext * b_ext;
  end

  mac_sat_add #(
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED),
    .SAT    (SAT)
  ) u_sat_add (
    .a   (acc),
    .b   (p1_ext),
    .sum (sum),
    .ovf (sum_ovf)
  );

  // Multiply stage, accumulate stage and output register, all held on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      last1     <= 1'b0;
      p1        <= '0;
      acc       <= '0;
      ovf_acc   <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out       <= '0;
      out_ovf   <= 1'b0;
      out_cnt   <= '0;
    end else if (adv) begin
      v1 <= accept;
      if (accept) begin
        p1    <= prod;
        last1 <= in_last;
      end
      // adv with out_valid set implies out_ready, so the held result leaves now.
      out_valid <= 1'b0;
      if (v1) begin
        if (last1) begin
          out       <= sum;
          out_ovf   <= ovf_acc | sum_ovf;
          out_cnt   <= cnt + CNT_W'(1);
          out_valid <= 1'b1;
          acc       <= '0;
          ovf_acc   <= 1'b0;
          cnt       <= '0;
        end else begin
          acc     <= sum;
          ovf_acc <= ovf_acc | sum_ovf;
          cnt     <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_acc_pipe.sv
// Scoreboard bench for mac_acc_pipe: four instances cover unsigned/signed,
// 32/25-bit accumulators and clamp/wrap. Directed vectors push hand-computed
// results into per-instance queues; a negedge monitor pops on every handshake.
module tb_mac_acc_pipe;

  typedef struct packed {
    logic [31:0] val;
    logic        ovf;
    logic [7:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [11:0] in_1 = '0;
  logic [11:0] in_2 = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  int          sel = 0;

  logic [3:0]  rdy;
  logic [3:0]  ov;
  logic [3:0]  ovf_o;
  logic [7:0]  cnt_o [4];
  logic [31:0] ox [4];
  logic [24:0] o2;
  logic [24:0] o3;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mac_acc_pipe u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 0), .in_ready(rdy[0]),
    .in_1(in_1), .in_2(in_2), .in_last(in_last), .out_valid(ov[0]),
    .out_ready(out_ready), .out(ox[0]), .out_ovf(ovf_o[0]), .out_cnt(cnt_o[0])
  );

  mac_acc_pipe #(.SIGNED(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 1), .in_ready(rdy[1]),
    .in_1(in_1), .in_2(in_2), .in_last(in_last), .out_valid(ov[1]),
    .out_ready(out_ready), .out(ox[1]), .out_ovf(ovf_o[1]), .out_cnt(cnt_o[1])
  );

  mac_acc_pipe #(.ACC_W(25), .SIGNED(1), .SAT(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 2), .in_ready(rdy[2]),
    .in_1(in_1), .in_2(in_2), .in_last(in_last), .out_valid(ov[2]),
    .out_ready(out_ready), .out(o2), .out_ovf(ovf_o[2]), .out_cnt(cnt_o[2])
  );

  mac_acc_pipe #(.ACC_W(25), .SIGNED(1), .SAT(0)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 3), .in_ready(rdy[3]),
    .in_1(in_1), .in_2(in_2), .in_last(in_last), .out_valid(ov[3]),
    .out_ready(out_ready), .out(o3), .out_ovf(ovf_o[3]), .out_cnt(cnt_o[3])
  );

  assign ox[2] = {{7{o2[24]}}, o2};
  assign ox[3] = {{7{o3[24]}}, o3};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, got, exp);
    end
  endtask

  task automatic push_exp(input int k, input logic [31:0] v, input logic o, input logic [7:0] c);
    exp_t e;
    e = '{val: v, ovf: o, cnt: c};
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  // Monitor: every result handed downstream must match the queue head.
  always @(negedge clk) begin
    if (!rst && out_ready) begin
      for (int k = 0; k < 4; k++) begin
        if (ov[k]) begin
          exp_t e;
          if (qsize(k) == 0) begin
            chk($sformatf("unexpected_out_u%0d", k), ox[k], 32'hx);
          end else begin
            case (k)
              0: e = q0.pop_front();
              1: e = q1.pop_front();
              2: e = q2.pop_front();
              default: e = q3.pop_front();
            endcase
            chk($sformatf("out_u%0d", k), ox[k], e.val);
            chk($sformatf("ovf_u%0d", k), {31'd0, ovf_o[k]}, {31'd0, e.ovf});
            chk($sformatf("cnt_u%0d", k), {24'd0, cnt_o[k]}, {24'd0, e.cnt});
          end
        end
      end
    end
  end

  // Present one pair to instance k and hold it until the handshake completes.
  task automatic send(input int k, input logic [11:0] a, input logic [11:0] b, input logic last);
    bit ok;
    sel      = k;
    in_1     = a;
    in_2     = b;
    in_last  = last;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = rdy[k];
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) chk($sformatf("send_timeout_u%0d", k), 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    bit seen;

    idle(3);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_state_u%0d", k),
          {ov[k], ovf_o[k], rdy[k], cnt_o[k], ox[k][20:0]}, {1'b0, 1'b0, 1'b1, 8'd0, 21'd0});
      chk($sformatf("rst_out_u%0d", k), ox[k], 32'd0);
    end
    @(posedge clk);
    #1;

    // Unsigned dot product 12+30+56, plus last-to-valid latency.
    push_exp(0, 32'd98, 1'b0, 8'd3);
    send(0, 12'd3, 12'd4, 1'b0);
    send(0, 12'd5, 12'd6, 1'b0);
    send(0, 12'd7, 12'd8, 1'b1);
    lat = 1;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (ov[0]) seen = 1'b1;
      else lat++;
    end
    // Edges from the accepting edge (counted as the first) to out_valid.
    chk("last_to_valid_edges", lat, 32'd2);
    @(posedge clk);
    #1;

    // Signed: -2048*2047 + -1*1.
    push_exp(1, -32'sd4192257, 1'b0, 8'd2);
    send(1, 12'h800, 12'h7FF, 1'b0);
    send(1, 12'hFFF, 12'h001, 1'b1);

    // 25-bit signed: three (-2048)^2 terms = 12582912 still fit below 2^24-1.
    push_exp(2, 32'd12582912, 1'b0, 8'd3);
    for (int i = 0; i < 3; i++) send(2, 12'h800, 12'h800, i == 2);
    // Four terms reach 2^24: clamp to the upper rail.
    push_exp(2, 32'd16777215, 1'b1, 8'd4);
    for (int i = 0; i < 4; i++) send(2, 12'h800, 12'h800, i == 3);
    // Fifth positive term stays pinned; a -1 term then steps off the rail.
    push_exp(2, 32'd16777214, 1'b1, 8'd6);
    for (int i = 0; i < 5; i++) send(2, 12'h800, 12'h800, 1'b0);
    send(2, 12'hFFF, 12'h001, 1'b1);
    // Wrap mode: 2^24 wraps to -2^24.
    push_exp(3, -32'sd16777216, 1'b1, 8'd4);
    for (int i = 0; i < 4; i++) send(3, 12'h800, 12'h800, i == 3);

    // Unsigned 32-bit overflow after 257 x 4095^2; the 8-bit count wraps to 1.
    push_exp(0, 32'hFFFF_FFFF, 1'b1, 8'd1);
    for (int i = 0; i < 257; i++) send(0, 12'hFFF, 12'hFFF, i == 256);
    idle(4);

    // Backpressure: result held for 10 cycles, next vector resumes intact.
    out_ready = 1'b0;
    push_exp(0, 32'd102, 1'b0, 8'd2);
    push_exp(0, 32'd25, 1'b0, 8'd2);
    fork
      begin
        send(0, 12'd10, 12'd10, 1'b0);
        send(0, 12'd1, 12'd2, 1'b1);
        send(0, 12'd3, 12'd3, 1'b0);
        send(0, 12'd4, 12'd4, 1'b1);
      end
      begin
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
          @(negedge clk);
          seen = ov[0];
        end
        chk("stall_wait_valid", {31'd0, seen}, 32'd1);
        for (int i = 0; i < 10; i++) begin
          if (i > 0) @(negedge clk);
          chk("stall_out", ox[0], 32'd102);
          chk("stall_flags", {ov[0], rdy[0], ovf_o[0], cnt_o[0]}, {1'b1, 1'b0, 1'b0, 8'd2});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(4);

    // Back-to-back single-term vectors: 6 then 20 on consecutive cycles.
    push_exp(0, 32'd6, 1'b0, 8'd1);
    push_exp(0, 32'd20, 1'b0, 8'd1);
    send(0, 12'd2, 12'd3, 1'b1);
    send(0, 12'd4, 12'd5, 1'b1);
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      seen = ov[0];
    end
    chk("b2b_first", ox[0], 32'd6);
    @(negedge clk);
    chk("b2b_second", {ov[0], ox[0][30:0]}, {1'b1, 31'd20});
    @(posedge clk);
    #1;
    idle(2);

    // Reset mid-vector drops the partial sum; the next vector starts clean.
    send(0, 12'd9, 12'd9, 1'b0);
    send(0, 12'd8, 12'd8, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_state", {ov[0], rdy[0]}, {1'b0, 1'b1});
    @(posedge clk);
    #1;
    push_exp(0, 32'd1, 1'b0, 8'd1);
    send(0, 12'd1, 12'd1, 1'b1);

    for (int n = 0; n < 50; n++) begin
      if (qsize(0) + qsize(1) + qsize(2) + qsize(3) == 0) break;
      idle(1);
    end
    idle(5);
    chk("sb_drain", qsize(0) + qsize(1) + qsize(2) + qsize(3), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
